polyfir_mac: RTL and testbench

Polyphase FIR multiply-accumulate engine for the resampler (I=3 interpolation, D=4 decimation). It sits directly downstream of the input-buffer address generator: on each `FirStart` it reads TAPS samples from input-buffer port B and TAPS coefficients of the selected phase `FirInSel`. It accumulates the products, then rounds and saturates the sum. Each result is written as one sample into the output buffer, with the write strobe `OutBufwea`.

---
 rtl/polyfir_mac.sv | 136 +++++++++++++
 tb/tb_polyfir_mac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polyfir_mac.sv
// Polyphase FIR multiply-accumulate engine: TAPS-tap dot product of one phase,
// rounded, saturated and written as a single output-buffer sample.
`timescale 1ns/1ps
module polyfir_mac #(
    parameter int       I      = 3,
    parameter int       TAPS   = 8,
    parameter int       DATA_W = 16,
    parameter int       ACC_W  = 40,
    parameter int       SHIFT  = 15,
    parameter logic [9:0] OUT_N = 10'h3ff
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              FirStart,
    input  logic [1:0]        FirInSel,
    input  logic [DATA_W-1:0] InBufDoutb,
    input  logic [DATA_W-1:0] CoefDout,
    output logic [4:0]        CoefAddr,
    output logic              SampleRd,
    output logic [DATA_W-1:0] OutBufDin,
    output logic [9:0]        OutBufAddra,
    output logic              OutBufwea,
    output logic              Busy,
    output logic              PhaseErr,
    output logic [1:0]        o_dbg_state
);
    localparam int TAP_W = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND     = {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [TAP_W-1:0]           r_tap;
    logic                       r_drain;
    logic [1:0]                 r_phase;
    logic                       r_v_rd, r_v1, r_v2;
    logic signed [DATA_W-1:0]   r_smp, r_coef;
    logic signed [2*DATA_W-1:0] r_prod;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]          r_out;
    logic [9:0]                 r_addr;

    logic                       w_phase_bad;
    logic signed [ACC_W-1:0]    w_prod_ext, w_acc_sum, w_rnd, w_shr;
    logic [DATA_W-1:0]          w_sat;

    assign w_phase_bad = (32'(r_phase) >= I);
    assign w_prod_ext  = {{(ACC_W-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod};
    // The last product is still in stage 2 during WRITE, so the output is
    // taken from the adder rather than the accumulator register.
    assign w_acc_sum   = r_v2 ? (r_acc + w_prod_ext) : r_acc;
    assign w_rnd       = w_acc_sum + RND;
    assign w_shr       = w_rnd >>> SHIFT;

    always_comb begin
        w_sat = w_shr[DATA_W-1:0];
        if (w_shr > SAT_MAX)
            w_sat = SAT_MAX[DATA_W-1:0];
        else if (w_shr < SAT_MIN)
            w_sat = SAT_MIN[DATA_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (FirStart) w_state_nxt = S_MAC;
            S_MAC:   if (r_tap == LAST_TAP) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tap   <= '0;
            r_drain <= 1'b0;
            r_phase <= 2'd0;
            r_acc   <= '0;
            r_out   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (FirStart) begin
                    r_phase <= FirInSel;
                    r_tap   <= '0;
                    r_drain <= 1'b0;
                    r_acc   <= '0;
                end
                S_MAC:   r_tap   <= (r_tap == LAST_TAP) ? '0 : r_tap + 1'b1;
                S_DRAIN: r_drain <= ~r_drain;
                S_WRITE: begin
                    r_out  <= w_sat;
                    r_addr <= (r_addr == OUT_N) ? 10'd0 : r_addr + 10'd1;
                end
                default: ;
            endcase
            if (r_v2 && !(r_state == S_IDLE && FirStart))
                r_acc <= w_acc_sum;
        end
    end

    // Valid bits follow each tap through memory read, operand and product stages;
    // a bad phase never marks a read valid, so the sum stays at zero.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_v_rd <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_smp  <= '0;
            r_coef <= '0;
            r_prod <= '0;
        end else begin
            r_v_rd <= (r_state == S_MAC) && !w_phase_bad;
            r_v1   <= r_v_rd;
            r_v2   <= r_v1;
            r_smp  <= InBufDoutb;
            r_coef <= CoefDout;
            r_prod <= r_smp * r_coef;
        end
    end

    assign CoefAddr    = (r_state == S_MAC && !w_phase_bad) ? (5'(r_phase * TAPS) + 5'(r_tap)) : 5'd0;
    assign SampleRd    = (r_state == S_MAC);
    assign OutBufwea   = (r_state == S_WRITE);
    assign PhaseErr    = (r_state == S_WRITE) && w_phase_bad;
    assign Busy        = (r_state != S_IDLE);
    assign OutBufDin   = (r_state == S_WRITE) ? w_sat : r_out;
    assign OutBufAddra = r_addr;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_polyfir_mac.sv
// Directed bench for polyfir_mac: memory models for input buffer and coefficient
// ROM, per-run observation driver and one task per scenario.
`timescale 1ns/1ps
module tb_polyfir_mac;
    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        FirStart = 1'b0;
    logic [1:0]  FirInSel = 2'd0;
    logic [15:0] InBufDoutb = 16'd0;
    logic [15:0] CoefDout = 16'd0;
    logic [4:0]  CoefAddr;
    logic        SampleRd;
    logic [15:0] OutBufDin;
    logic [9:0]  OutBufAddra;
    logic        OutBufwea;
    logic        Busy;
    logic        PhaseErr;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] smem [8];
    logic [15:0] crom [32];
    int          rd_cnt = 0;

    polyfir_mac dut (
        .sys_clk(sys_clk), .reset(reset), .FirStart(FirStart), .FirInSel(FirInSel),
        .InBufDoutb(InBufDoutb), .CoefDout(CoefDout), .CoefAddr(CoefAddr),
        .SampleRd(SampleRd), .OutBufDin(OutBufDin), .OutBufAddra(OutBufAddra),
        .OutBufwea(OutBufwea), .Busy(Busy), .PhaseErr(PhaseErr), .o_dbg_state(o_dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    // Memories with one cycle of read latency; the upstream address generator
    // is modelled by a read counter restarted on each accepted start.
    always @(posedge sys_clk) begin
        CoefDout <= crom[CoefAddr];
        if (FirStart && !Busy)
            rd_cnt <= 0;
        else if (SampleRd) begin
            InBufDoutb <= smem[rd_cnt[2:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Drives one start and observes cycles 1..12 after acceptance (cycle j ends at edge k+j).
    task automatic do_run(input logic [1:0] ph, output int wea_cnt, output int wea_cyc,
                          output logic [15:0] dout, output logic [9:0] addr_wea,
                          output logic [9:0] addr_after, output logic [15:0] dout_after,
                          output int perr_cnt, output int perr_cyc, output int coef_bad,
                          output int srd_bad, output int busy_bad);
        logic [4:0] exp_addr;
        wea_cnt = 0; wea_cyc = 0; dout = '0; addr_wea = '0; addr_after = '0; dout_after = '0;
        perr_cnt = 0; perr_cyc = 0; coef_bad = 0; srd_bad = 0; busy_bad = 0;
        @(negedge sys_clk);
        FirInSel = ph;
        FirStart = 1'b1;
        @(negedge sys_clk);
        FirStart = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (OutBufwea) begin
                wea_cnt++; wea_cyc = cyc; dout = OutBufDin; addr_wea = OutBufAddra;
            end
            if (PhaseErr) begin
                perr_cnt++; perr_cyc = cyc;
            end
            if (Busy !== (cyc <= 11)) busy_bad++;
            if (SampleRd !== (cyc <= 8)) srd_bad++;
            if (cyc <= 8) begin
                exp_addr = (ph == 2'd3) ? 5'd0 : 5'(ph * 8 + cyc - 1);
                if (CoefAddr !== exp_addr) coef_bad++;
            end
            if (cyc == 12) begin
                addr_after = OutBufAddra; dout_after = OutBufDin;
            end
            if (cyc < 12) @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++; if (OutBufwea !== 1'b0) begin errors++; $display("FAIL reset_wea: got %b want 0", OutBufwea); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (SampleRd !== 1'b0) begin errors++; $display("FAIL reset_samplerd: got %b want 0", SampleRd); end
        checks++; if (PhaseErr !== 1'b0) begin errors++; $display("FAIL reset_phaseerr: got %b want 0", PhaseErr); end
        checks++; if (CoefAddr !== 5'd0) begin errors++; $display("FAIL reset_coefaddr: got %0d want 0", CoefAddr); end
        checks++; if (OutBufAddra !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", OutBufAddra); end
        checks++; if (OutBufDin !== 16'd0) begin errors++; $display("FAIL reset_dout: got %0h want 0", OutBufDin); end
        checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
        reset = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_basic_sum();
        int wc, wcy, pc, pcy, cb, sb, bb;
        logic [15:0] d, da;
        logic [9:0] aw, aa;
        for (int i = 0; i < 8; i++) smem[i] = 16'(i + 1);
        for (int i = 0; i < 32; i++) crom[i] = 16'h1234;
        for (int i = 8; i < 16; i++) crom[i] = 16'h4000;
        do_run(2'd1, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (wc !== 1) begin errors++; $display("FAIL basic_wea_count: got %0d want 1", wc); end
        checks++; if (wcy !== 11) begin errors++; $display("FAIL basic_wea_latency: got %0d want 11", wcy); end
        checks++; if (d !== 16'd18) begin errors++; $display("FAIL basic_dout: got %0h want 12", d); end
        checks++; if (aw !== 10'd0) begin errors++; $display("FAIL basic_addr_write: got %0h want 0", aw); end
        checks++; if (aa !== 10'd1) begin errors++; $display("FAIL basic_addr_after: got %0h want 1", aa); end
        checks++; if (cb !== 0) begin errors++; $display("FAIL basic_coefaddr: got %0d bad cycles want 0", cb); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL basic_samplerd: got %0d bad cycles want 0", sb); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles want 0", bb); end
        checks++; if (pc !== 0) begin errors++; $display("FAIL basic_phaseerr: got %0d pulses want 0", pc); end
    endtask

    task automatic test_saturation();
        int wc, wcy, pc, pcy, cb, sb, bb;
        logic [15:0] d, da;
        logic [9:0] aw, aa;
        for (int i = 0; i < 32; i++) crom[i] = 16'h7fff;
        for (int i = 0; i < 8; i++) smem[i] = 16'h7fff;
        do_run(2'd0, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (d !== 16'h7fff) begin errors++; $display("FAIL sat_pos: got %0h want 7fff", d); end
        checks++; if (aw !== 10'd1) begin errors++; $display("FAIL sat_pos_addr: got %0h want 1", aw); end
        for (int i = 0; i < 8; i++) smem[i] = 16'h8000;
        do_run(2'd0, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %0h want 8000", d); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL sat_neg_wea_count: got %0d want 1", wc); end
    endtask

    task automatic test_rounding();
        int wc, wcy, pc, pcy, cb, sb, bb;
        logic [15:0] d, da;
        logic [9:0] aw, aa;
        for (int i = 0; i < 32; i++) crom[i] = 16'h4000;
        for (int i = 0; i < 8; i++) smem[i] = 16'h0000;
        smem[5] = 16'd3;
        do_run(2'd2, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (d !== 16'd2) begin errors++; $display("FAIL round_pos: got %0h want 2", d); end
        checks++; if (da !== 16'd2) begin errors++; $display("FAIL round_pos_hold: got %0h want 2", da); end
        checks++; if (cb !== 0) begin errors++; $display("FAIL round_coefaddr_ph2: got %0d bad cycles want 0", cb); end
        smem[5] = 16'hfffd;
        do_run(2'd2, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (d !== 16'hffff) begin errors++; $display("FAIL round_neg: got %0h want ffff", d); end
        repeat (3) @(negedge sys_clk);
        checks++; if (OutBufDin !== 16'hffff) begin errors++; $display("FAIL round_neg_hold: got %0h want ffff", OutBufDin); end
    endtask

    task automatic test_bad_phase();
        int wc, wcy, pc, pcy, cb, sb, bb;
        logic [15:0] d, da;
        logic [9:0] aw, aa;
        for (int i = 0; i < 8; i++) smem[i] = 16'(i + 1);
        for (int i = 0; i < 32; i++) crom[i] = 16'h4000;
        do_run(2'd3, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (cb !== 0) begin errors++; $display("FAIL badph_coefaddr: got %0d nonzero cycles want 0", cb); end
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL badph_dout: got %0h want 0", d); end
        checks++; if (wcy !== 11) begin errors++; $display("FAIL badph_wea_cycle: got %0d want 11", wcy); end
        checks++; if (pc !== 1) begin errors++; $display("FAIL badph_perr_count: got %0d want 1", pc); end
        checks++; if (pcy !== 11) begin errors++; $display("FAIL badph_perr_cycle: got %0d want 11", pcy); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL badph_samplerd: got %0d bad cycles want 0", sb); end
    endtask

    task automatic test_start_conflict();
        int wea_n = 0;
        int wea2_n = 0;
        int wea2_cyc = 0;
        logic busy12 = 1'b0;
        logic busy13 = 1'b0;
        @(negedge sys_clk);
        FirInSel = 2'd0;
        FirStart = 1'b1;
        @(negedge sys_clk);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (OutBufwea) begin
                if (cyc <= 12) wea_n++;
                else begin wea2_n++; wea2_cyc = cyc; end
            end
            if (cyc == 12) busy12 = Busy;
            if (cyc == 13) busy13 = Busy;
            FirStart = (cyc == 3 || cyc == 11 || cyc == 12);
            @(negedge sys_clk);
        end
        FirStart = 1'b0;
        checks++; if (wea_n !== 1) begin errors++; $display("FAIL conflict_first_wea_count: got %0d want 1", wea_n); end
        checks++; if (busy12 !== 1'b0) begin errors++; $display("FAIL conflict_write_start_ignored: busy got %b want 0", busy12); end
        checks++; if (busy13 !== 1'b1) begin errors++; $display("FAIL conflict_restart_busy: got %b want 1", busy13); end
        checks++; if (wea2_n !== 1 || wea2_cyc !== 23) begin
            errors++; $display("FAIL conflict_second_run: got %0d writes at cycle %0d want 1 at 23", wea2_n, wea2_cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        int wea_n = 0;
        @(negedge sys_clk);
        FirInSel = 2'd1;
        FirStart = 1'b1;
        @(negedge sys_clk);
        FirStart = 1'b0;
        repeat (4) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", Busy); end
        checks++; if (OutBufAddra !== 10'd0) begin errors++; $display("FAIL midrst_addr: got %0h want 0", OutBufAddra); end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (OutBufwea) wea_n++;
            @(negedge sys_clk);
        end
        checks++; if (wea_n !== 0) begin errors++; $display("FAIL midrst_no_write: got %0d writes want 0", wea_n); end
    endtask

    task automatic test_addr_wrap();
        int wc, wcy, pc, pcy, cb, sb, bb;
        logic [15:0] d, da;
        logic [9:0] aw, aa;
        for (int r = 0; r < 1023; r++)
            do_run(2'd0, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (aa !== 10'h3ff) begin errors++; $display("FAIL wrap_preload: got %0h want 3ff", aa); end
        do_run(2'd0, wc, wcy, d, aw, aa, da, pc, pcy, cb, sb, bb);
        checks++; if (aw !== 10'h3ff) begin errors++; $display("FAIL wrap_write_addr: got %0h want 3ff", aw); end
        checks++; if (aa !== 10'h000) begin errors++; $display("FAIL wrap_after: got %0h want 0", aa); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) smem[i] = 16'd0;
        for (int i = 0; i < 32; i++) crom[i] = 16'd0;
        test_reset();
        test_basic_sum();
        test_saturation();
        test_rounding();
        test_bad_phase();
        test_start_conflict();
        test_reset_mid_run();
        test_addr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
